// File: rtl/draw_sprite.sv
// Overlays a frame-latched, optionally mirrored SPR_W x SPR_H sprite from an external pixel memory onto the VGA stream.
// Latency MEM_LAT+1 clocks (pixel_addr is combinational); one pixel per clock, no backpressure.
module draw_sprite #(
    parameter int          SPR_W     = 512,
    parameter int          SPR_H     = 158,
    parameter int          AX_W      = 9,
    parameter int          AY_W      = 8,
    parameter int          MEM_LAT   = 1,
    parameter logic [11:0] KEY_COLOR = 12'hFFF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [10:0]          hcount_in,
    input  logic [10:0]          vcount_in,
    input  logic                 hsync_in,
    input  logic                 hblnk_in,
    input  logic                 vsync_in,
    input  logic                 vblnk_in,
    input  logic [11:0]          rgb_in,
    input  logic [11:0]          xpos,
    input  logic [11:0]          ypos,
    input  logic                 mirror,
    input  logic                 enable,
    input  logic [11:0]          rgb_pixel,
    output logic [10:0]          hcount_out,
    output logic [10:0]          vcount_out,
    output logic                 hsync_out,
    output logic                 hblnk_out,
    output logic                 vsync_out,
    output logic                 vblnk_out,
    output logic [11:0]          rgb_out,
    output logic [AY_W+AX_W-1:0] pixel_addr,
    output logic                 drawn
);

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        hblnk;
        logic        vsync;
        logic        vblnk;
        logic [11:0] rgb;
        logic        hit;
    } pix_t;

    logic        vblnk_prev;
    logic        latch_edge;
    logic [11:0] xl;
    logic [11:0] yl;
    logic        ml;
    logic        el;

    assign latch_edge = vblnk_in & ~vblnk_prev;

    // Geometry is sampled once per frame so a moving sprite never tears.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vblnk_prev <= 1'b0;
            xl         <= '0;
            yl         <= '0;
            ml         <= 1'b0;
            el         <= 1'b0;
        end else begin
            vblnk_prev <= vblnk_in;
            if (latch_edge) begin
                xl <= xpos;
                yl <= ypos;
                ml <= mirror;
                el <= enable;
            end
        end
    end

    logic [12:0]     h_ext, v_ext, x_lo, x_hi, y_lo, y_hi;
    logic            hit;
    logic [AX_W-1:0] addrx;
    logic [AY_W-1:0] addry;

    // 13-bit window bounds: a sprite running past column 2047 clips instead of wrapping.
    assign h_ext = {2'b00, hcount_in};
    assign v_ext = {2'b00, vcount_in};
    assign x_lo  = {1'b0, xl};
    assign y_lo  = {1'b0, yl};
    assign x_hi  = x_lo + 13'(SPR_W);
    assign y_hi  = y_lo + 13'(SPR_H);

    assign hit = el && (h_ext >= x_lo) && (h_ext < x_hi) &&
                       (v_ext >= y_lo) && (v_ext < y_hi);

    assign addry = AY_W'(v_ext - y_lo);
    assign addrx = ml ? AX_W'(13'(SPR_W - 1) - (h_ext - x_lo)) : AX_W'(h_ext - x_lo);

    assign pixel_addr = hit ? {addry, addrx} : '0;

    pix_t pix_in;
    pix_t pix_d;
    pix_t pipe [MEM_LAT];

    always_comb begin
        pix_in = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in, hblnk: hblnk_in,
                   vsync: vsync_in, vblnk: vblnk_in, rgb: rgb_in, hit: hit};
    end

    // Matches the pixel memory read latency so rgb_pixel lines up with its pixel.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < MEM_LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= pix_in;
            for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign pix_d = pipe[MEM_LAT-1];

    logic blank_d;
    logic opaque_px;
    logic sticky;

    assign blank_d   = pix_d.hblnk | pix_d.vblnk;
    assign opaque_px = !blank_d && pix_d.hit && (rgb_pixel != KEY_COLOR);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hcount_out <= '0;
            vcount_out <= '0;
            hsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vsync_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= '0;
            sticky     <= 1'b0;
            drawn      <= 1'b0;
        end else begin
            hcount_out <= pix_d.hcount;
            vcount_out <= pix_d.vcount;
            hsync_out  <= pix_d.hsync;
            hblnk_out  <= pix_d.hblnk;
            vsync_out  <= pix_d.vsync;
            vblnk_out  <= pix_d.vblnk;
            if (blank_d)
                rgb_out <= 12'h000;
            else if (opaque_px)
                rgb_out <= rgb_pixel;
            else
                rgb_out <= pix_d.rgb;
            // A pixel emitted on the latch clock still belongs to the frame being closed.
            if (latch_edge) begin
                drawn  <= sticky | opaque_px;
                sticky <= 1'b0;
            end else if (opaque_px) begin
                sticky <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_draw_sprite.sv
// Bench for draw_sprite: constant-expectation vector table, directed multi-cycle sequences,
// then randomized frames checked cycle by cycle against an arithmetic reference model.
`timescale 1ns/1ps
module tb_draw_sprite;
    localparam int          W   = 512;
    localparam int          H   = 158;
    localparam int          AX  = 9;
    localparam int          AY  = 8;
    localparam int          LAT = 1;
    localparam logic [11:0] KEY = 12'hFFF;

    logic              clk, reset_n;
    logic [10:0]       hcount_in, vcount_in;
    logic              hsync_in, hblnk_in, vsync_in, vblnk_in;
    logic [11:0]       rgb_in, xpos, ypos;
    logic              mirror, enable;
    logic [11:0]       rgb_pixel;
    logic [10:0]       hcount_out, vcount_out;
    logic              hsync_out, hblnk_out, vsync_out, vblnk_out;
    logic [11:0]       rgb_out;
    logic [AY+AX-1:0]  pixel_addr;
    logic              drawn;

    draw_sprite #(.SPR_W(W), .SPR_H(H), .AX_W(AX), .AY_W(AY), .MEM_LAT(LAT), .KEY_COLOR(KEY)) dut (
        .clk(clk), .reset_n(reset_n),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .hblnk_in(hblnk_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos), .mirror(mirror), .enable(enable),
        .rgb_pixel(rgb_pixel),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .hblnk_out(hblnk_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out), .pixel_addr(pixel_addr), .drawn(drawn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [10:0] h, v;
        logic        hs, hb, vs, vb;
        logic [11:0] rgb, xpos, ypos;
        logic        mirror, enable;
    } in_t;

    typedef struct packed {
        logic [10:0] h, v;
        logic        hs, hb, vs, vb;
        logic [11:0] rgb;
    } out_t;

    typedef struct packed {
        logic [11:0]      xpos, ypos;
        logic             mirror, enable;
        logic [10:0]      h, v;
        logic             hb;
        logic [11:0]      memc;
        logic [AY+AX-1:0] exp_addr;
        logic [11:0]      exp_rgb;
    } vec_t;

    int vectors = 0;
    int miscompares = 0;

    in_t  stim;
    out_t expq [$];
    bit   c2q  [$];
    int   xl_m, yl_m;
    bit   ml_m, el_m, prev_m, sticky_m, drawn_m;

    // Pixel memory: contents are either a fixed colour or an address-derived pattern.
    int          mem_mode, mode_a;
    logic [11:0] mem_const, const_a;
    logic [11:0] mem_pipe [LAT];

    function automatic logic [11:0] mem_val(input logic [AY+AX-1:0] a);
        if (mode_a == 1) return const_a;
        return a[11:0] ^ {7'd0, a[16:12]} ^ 12'h35C;
    endfunction

    always @(posedge clk) begin
        mem_pipe[0] <= mem_val(pixel_addr);
        for (int i = 1; i < LAT; i++) mem_pipe[i] <= mem_pipe[i-1];
    end
    assign rgb_pixel = mem_pipe[LAT-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        xl_m = 0; yl_m = 0; ml_m = 0; el_m = 0;
        prev_m = 0; sticky_m = 0; drawn_m = 0;
        expq.delete();
        c2q.delete();
        repeat (LAT + 1) expq.push_back('0);
        repeat (LAT) c2q.push_back(1'b0);
    endtask

    task automatic model_pix(input in_t s, output bit hit, output logic [AY+AX-1:0] a);
        int h, v, dx, dy, ax;
        h   = int'(s.h);
        v   = int'(s.v);
        hit = el_m && h >= xl_m && h < xl_m + W && v >= yl_m && v < yl_m + H;
        dx  = h - xl_m;
        dy  = v - yl_m;
        ax  = ml_m ? (W - 1 - dx) : dx;
        a   = hit ? (AY+AX)'(dy * (1 << AX) + ax) : '0;
    endtask

    task automatic apply_stim();
        hcount_in = stim.h;  vcount_in = stim.v;
        hsync_in  = stim.hs; hblnk_in  = stim.hb;
        vsync_in  = stim.vs; vblnk_in  = stim.vb;
        rgb_in    = stim.rgb;
        xpos      = stim.xpos; ypos = stim.ypos;
        mirror    = stim.mirror; enable = stim.enable;
        mode_a    = mem_mode; const_a = mem_const;
    endtask

    // One pixel clock: check outputs due now, drive the next pixel, predict its result.
    task automatic step();
        out_t             e, ne;
        bit               hit, c2, opaque, blank;
        logic [AY+AX-1:0] ea;
        logic [11:0]      mv;
        @(negedge clk);
        e = expq.pop_front();
        check("hcount_out", 32'(hcount_out), 32'(e.h));
        check("vcount_out", 32'(vcount_out), 32'(e.v));
        check("hsync_out",  32'(hsync_out),  32'(e.hs));
        check("hblnk_out",  32'(hblnk_out),  32'(e.hb));
        check("vsync_out",  32'(vsync_out),  32'(e.vs));
        check("vblnk_out",  32'(vblnk_out),  32'(e.vb));
        check("rgb_out",    32'(rgb_out),    32'(e.rgb));
        check("drawn",      32'(drawn),      32'(drawn_m));
        apply_stim();
        #1;
        model_pix(stim, hit, ea);
        check("pixel_addr", 32'(pixel_addr), 32'(ea));
        mv     = mem_val(ea);
        blank  = stim.hb || stim.vb;
        opaque = hit && (mv != KEY) && !blank;
        ne.h = stim.h; ne.v = stim.v; ne.hs = stim.hs; ne.hb = stim.hb;
        ne.vs = stim.vs; ne.vb = stim.vb;
        ne.rgb = blank ? 12'h000 : (opaque ? mv : stim.rgb);
        expq.push_back(ne);
        c2q.push_back(opaque);
        c2 = c2q.pop_front();
        if (stim.vb && !prev_m) begin
            drawn_m  = sticky_m || c2;
            sticky_m = 0;
            xl_m = int'(stim.xpos); yl_m = int'(stim.ypos);
            ml_m = stim.mirror;     el_m = stim.enable;
        end else if (c2) begin
            sticky_m = 1;
        end
        prev_m = stim.vb;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rst_hcount", 32'(hcount_out), 0);
        check("rst_vcount", 32'(vcount_out), 0);
        check("rst_sync",   32'({hsync_out, vsync_out}), 0);
        check("rst_blank",  32'({hblnk_out, vblnk_out}), 0);
        check("rst_rgb",    32'(rgb_out), 0);
        check("rst_addr",   32'(pixel_addr), 0);
        check("rst_drawn",  32'(drawn), 0);
        model_reset();
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
    endtask

    // The pixel before a vblank rise is always in hblank, as on a real raster.
    task automatic latch_frame(input logic [11:0] x, input logic [11:0] y, input logic m, input logic en);
        stim.vb = 1'b0; stim.hb = 1'b1;
        step();
        stim.vb = 1'b1; stim.xpos = x; stim.ypos = y; stim.mirror = m; stim.enable = en;
        step();
        stim.vb = 1'b0; stim.hb = 1'b0;
        step();
    endtask

    vec_t tbl [18];

    initial begin
        int cnt, hh, vv;
        tbl[0]  = '{12'd100,  12'd50, 1'b0, 1'b1, 11'd100,  11'd50,  1'b0, 12'h0F0, 17'd0,            12'h0F0};
        tbl[1]  = '{12'd100,  12'd50, 1'b0, 1'b1, 11'd611,  11'd207, 1'b0, 12'h0F0, {8'd157, 9'd511}, 12'h0F0};
        tbl[2]  = '{12'd100,  12'd50, 1'b0, 1'b1, 11'd99,   11'd50,  1'b0, 12'h0F0, 17'd0,            12'h123};
        tbl[3]  = '{12'd100,  12'd50, 1'b0, 1'b1, 11'd612,  11'd207, 1'b0, 12'h0F0, 17'd0,            12'h123};
        tbl[4]  = '{12'd100,  12'd50, 1'b0, 1'b1, 11'd100,  11'd50,  1'b0, 12'hFFF, 17'd0,            12'h123};
        tbl[5]  = '{12'd100,  12'd50, 1'b0, 1'b1, 11'd101,  11'd51,  1'b1, 12'h0F0, {8'd1, 9'd1},     12'h000};
        tbl[6]  = '{12'd100,  12'd50, 1'b0, 1'b1, 11'd100,  11'd49,  1'b0, 12'h0F0, 17'd0,            12'h123};
        tbl[7]  = '{12'd100,  12'd50, 1'b0, 1'b1, 11'd100,  11'd207, 1'b0, 12'h0F0, {8'd157, 9'd0},   12'h0F0};
        tbl[8]  = '{12'd100,  12'd50, 1'b0, 1'b1, 11'd100,  11'd208, 1'b0, 12'h0F0, 17'd0,            12'h123};
        tbl[9]  = '{12'd0,    12'd0,  1'b1, 1'b1, 11'd0,    11'd0,   1'b0, 12'h0F0, {8'd0, 9'd511},   12'h0F0};
        tbl[10] = '{12'd0,    12'd0,  1'b1, 1'b1, 11'd511,  11'd0,   1'b0, 12'h0F0, 17'd0,            12'h0F0};
        tbl[11] = '{12'd0,    12'd0,  1'b1, 1'b1, 11'd10,   11'd3,   1'b0, 12'h0F0, {8'd3, 9'd501},   12'h0F0};
        tbl[12] = '{12'd0,    12'd0,  1'b1, 1'b1, 11'd512,  11'd0,   1'b0, 12'h0F0, 17'd0,            12'h123};
        tbl[13] = '{12'd1800, 12'd0,  1'b0, 1'b1, 11'd1800, 11'd0,   1'b0, 12'h0F0, 17'd0,            12'h0F0};
        tbl[14] = '{12'd1800, 12'd0,  1'b0, 1'b1, 11'd2047, 11'd5,   1'b0, 12'h0F0, {8'd5, 9'd247},   12'h0F0};
        tbl[15] = '{12'd1800, 12'd0,  1'b0, 1'b1, 11'd100,  11'd0,   1'b0, 12'h0F0, 17'd0,            12'h123};
        tbl[16] = '{12'd1800, 12'd0,  1'b0, 1'b1, 11'd263,  11'd0,   1'b0, 12'h0F0, 17'd0,            12'h123};
        tbl[17] = '{12'd100,  12'd50, 1'b0, 1'b0, 11'd100,  11'd50,  1'b0, 12'h0F0, 17'd0,            12'h123};

        reset_n   = 1'b1;
        stim      = '0;
        stim.rgb  = 12'h123;
        mem_mode  = 1;
        mem_const = KEY;
        apply_stim();
        do_reset();

        // Sprite stays hidden before the first latch edge.
        stim.h = 11'd0; stim.v = 11'd0;
        stim.xpos = 12'd0; stim.ypos = 12'd0; stim.enable = 1'b1;
        step();
        check("first_frame_hidden", 32'(pixel_addr), 0);

        for (int r = 0; r < 18; r++) begin
            mem_mode = 1; mem_const = tbl[r].memc;
            latch_frame(tbl[r].xpos, tbl[r].ypos, tbl[r].mirror, tbl[r].enable);
            stim.h = tbl[r].h; stim.v = tbl[r].v; stim.hb = tbl[r].hb; stim.rgb = 12'h123;
            step();
            check($sformatf("row%0d_addr", r), 32'(pixel_addr), 32'(tbl[r].exp_addr));
            stim.hb = 1'b1; stim.h = 11'd0; stim.v = 11'd0;
            repeat (LAT + 1) step();
            check($sformatf("row%0d_rgb", r), 32'(rgb_out), 32'(tbl[r].exp_rgb));
        end

        // Mid-frame request changes are ignored until the next latch edge.
        mem_mode = 1; mem_const = 12'h0F0; stim.rgb = 12'h123;
        latch_frame(12'd100, 12'd0, 1'b0, 1'b1);
        stim.xpos = 12'd300; stim.h = 11'd650; stim.v = 11'd10; stim.hb = 1'b0;
        step();
        check("tear_old_window", 32'(pixel_addr), 0);
        stim.h = 11'd150;
        step();
        check("tear_old_hit", 32'(pixel_addr), 32'({8'd10, 9'd50}));
        stim.h = 11'd650; stim.hb = 1'b1;
        step();
        stim.vb = 1'b1;
        step();
        check("latch_clk_uses_old", 32'(pixel_addr), 0);
        stim.vb = 1'b0; stim.hb = 1'b0;
        step();
        check("tear_new_window", 32'(pixel_addr), 32'({8'd10, 9'd350}));
        stim.h = 11'd150;
        step();
        check("tear_old_gone", 32'(pixel_addr), 0);

        // Reset in the middle of a drawn line, then sprite stays off until a latch edge.
        stim.h = 11'd400;
        repeat (3) step();
        do_reset();
        step();
        check("post_reset_hidden", 32'(pixel_addr), 0);
        repeat (LAT + 1) step();
        check("post_reset_rgb_in", 32'(rgb_out), 32'(12'h123));
        latch_frame(12'd300, 12'd0, 1'b0, 1'b1);
        stim.h = 11'd400; stim.v = 11'd10;
        step();
        check("post_reset_relatch", 32'(pixel_addr), 32'({8'd10, 9'd100}));

        // Drawn flag: one opaque pixel sets it, an all-transparent frame clears it.
        mem_mode = 1; mem_const = KEY;
        latch_frame(12'd0, 12'd0, 1'b0, 1'b1);
        stim.h = 11'd5; stim.v = 11'd5; mem_const = 12'h0F0;
        step();
        mem_const = KEY; stim.h = 11'd1000; stim.v = 11'd1000;
        repeat (3) step();
        latch_frame(12'd0, 12'd0, 1'b0, 1'b1);
        check("drawn_set", 32'(drawn), 1);
        stim.h = 11'd5; stim.v = 11'd5;
        repeat (4) step();
        stim.h = 11'd1000; stim.v = 11'd1000;
        repeat (3) step();
        latch_frame(12'd0, 12'd0, 1'b0, 1'b1);
        check("drawn_clear", 32'(drawn), 0);

        // Randomized frames with jittering requests, blanking and memory contents.
        cnt = 1; stim.vb = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (cnt == 0) begin
                stim.vb = ~stim.vb;
                cnt = stim.vb ? int'($urandom_range(2, 5)) : int'($urandom_range(20, 80));
            end
            cnt--;
            stim.hb = (!stim.vb && cnt == 0) ? 1'b1 : ($urandom_range(0, 9) == 0);
            stim.hs = 1'($urandom_range(0, 1));
            stim.vs = 1'($urandom_range(0, 1));
            stim.rgb = 12'($urandom_range(0, 4095));
            stim.xpos = ($urandom_range(0, 9) == 0) ? 12'($urandom_range(1700, 2047))
                                                   : 12'($urandom_range(0, 1600));
            stim.ypos = 12'($urandom_range(0, 400));
            stim.mirror = 1'($urandom_range(0, 1));
            stim.enable = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 7) == 0) hh = int'($urandom_range(0, 2047));
            else hh = xl_m - 16 + int'($urandom_range(0, W + 32));
            if ($urandom_range(0, 7) == 0) vv = int'($urandom_range(0, 2047));
            else vv = yl_m - 8 + int'($urandom_range(0, H + 16));
            if (hh < 0) hh = 0;
            if (hh > 2047) hh = 2047;
            if (vv < 0) vv = 0;
            if (vv > 2047) vv = 2047;
            stim.h = 11'(hh);
            stim.v = 11'(vv);
            mem_mode  = ($urandom_range(0, 7) == 0) ? 1 : 0;
            mem_const = ($urandom_range(0, 1) == 0) ? KEY : 12'($urandom_range(0, 4094));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
